cache_exception_pipe: RTL and testbench

- Registered, handshaked alignment-exception stage for the cache request path. Sits between address generation and cache tag lookup.
- Checks each access against its byte-mask size and raises ALE (the `EXP_ALE` encoding from exception.vh) when the address is misaligned. Cache-op requests are never flagged.
- Generalises the earlier combinational checker: parametrised address width and maximum access size (up to 8 bytes), 2-entry skid buffering, flush, a sticky first-fault record and a saturating fault counter.

---
 rtl/cache_exception_pipe.sv | 127 ++++++++++++
 tb/tb_cache_exception_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_exception_pipe.sv
// Registered, handshaked alignment-exception stage (output register + one skid entry).
// Build option: define CACHE_EXP_ILLEGAL_MASK_EN to raise ALE on illegal byte masks.
`ifndef EXP_ALE
`define EXP_ALE 7'h09
`endif

module cache_exception_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BYTES  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [MAX_BYTES-1:0]  in_type,
  input  logic                  in_cacop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_cacop,
  output logic [6:0]            out_exception,
  output logic                  fault_seen,
  output logic [ADDR_WIDTH-1:0] fault_badv,
  output logic [CNT_WIDTH-1:0]  fault_count
);

  localparam int LOG_MAX = $clog2(MAX_BYTES);

  logic                  mask_legal;
  logic                  misaligned;
  logic                  raise_ale;
  logic [6:0]            in_exception;
  logic                  in_ready_r;
  logic                  in_fire;
  logic                  out_fire;
  logic                  skid_valid;
  logic                  skid_valid_nxt;
  logic [ADDR_WIDTH-1:0] skid_addr;
  logic                  skid_cacop;
  logic [6:0]            skid_exception;

  // A mask of 2^size - 1 selects an access of `size` bytes; alignment needs log2(size) low zeros.
  always_comb begin
    mask_legal = 1'b0;
    misaligned = 1'b0;
    for (int i = 0; i <= LOG_MAX; i++) begin
      if (in_type == MAX_BYTES'((1 << (1 << i)) - 1)) begin
        mask_legal = 1'b1;
        misaligned = |(in_addr & ADDR_WIDTH'((1 << i) - 1));
      end
    end
`ifdef CACHE_EXP_ILLEGAL_MASK_EN
    raise_ale = misaligned | ~mask_legal;
`else
    raise_ale = misaligned & mask_legal;
`endif
    in_exception = (raise_ale && !in_cacop) ? `EXP_ALE : 7'd0;
  end

  assign in_ready = in_ready_r;
  assign in_fire  = in_valid && in_ready_r && !flush;
  assign out_fire = out_valid && out_ready;

  // in_ready_r is only high while the skid is empty, so a skid drain never coincides with an accept.
  always_comb begin
    if (skid_valid) skid_valid_nxt = !out_fire;
    else            skid_valid_nxt = in_fire && out_valid && !out_fire;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_ready_r     <= 1'b0;
      out_valid      <= 1'b0;
      out_addr       <= '0;
      out_cacop      <= 1'b0;
      out_exception  <= 7'd0;
      skid_valid     <= 1'b0;
      skid_addr      <= '0;
      skid_cacop     <= 1'b0;
      skid_exception <= 7'd0;
      fault_seen     <= 1'b0;
      fault_badv     <= '0;
      fault_count    <= '0;
    end else if (flush) begin
      in_ready_r  <= 1'b1;
      out_valid   <= 1'b0;
      skid_valid  <= 1'b0;
      fault_seen  <= 1'b0;
      fault_badv  <= '0;
      fault_count <= '0;
    end else begin
      in_ready_r <= !skid_valid_nxt;
      skid_valid <= skid_valid_nxt;
      if (in_fire && out_valid && !out_fire) begin
        skid_addr      <= in_addr;
        skid_cacop     <= in_cacop;
        skid_exception <= in_exception;
      end
      if (!out_valid || out_fire) begin
        if (skid_valid) begin
          out_valid     <= 1'b1;
          out_addr      <= skid_addr;
          out_cacop     <= skid_cacop;
          out_exception <= skid_exception;
        end else if (in_fire) begin
          out_valid     <= 1'b1;
          out_addr      <= in_addr;
          out_cacop     <= in_cacop;
          out_exception <= in_exception;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (out_fire && out_exception != 7'd0) begin
        if (fault_count != '1) fault_count <= fault_count + 1'b1;
        if (!fault_seen) begin
          fault_seen <= 1'b1;
          fault_badv <= out_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_exception_pipe.sv
// Directed self-checking bench for cache_exception_pipe (CNT_WIDTH=2 to reach saturation quickly).
`ifndef EXP_ALE
`define EXP_ALE 7'h09
`endif

module tb_cache_exception_pipe;
  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready, in_cacop;
  logic [31:0] in_addr;
  logic [7:0]  in_type;
  logic        out_valid, out_ready, out_cacop;
  logic [31:0] out_addr;
  logic [6:0]  out_exception;
  logic        fault_seen;
  logic [31:0] fault_badv;
  logic [1:0]  fault_count;
  int checks = 0;
  int errors = 0;

  cache_exception_pipe #(.ADDR_WIDTH(32), .MAX_BYTES(8), .CNT_WIDTH(2)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_type(in_type), .in_cacop(in_cacop),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_cacop(out_cacop),
    .out_exception(out_exception), .fault_seen(fault_seen), .fault_badv(fault_badv),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [7:0] t, input logic c);
    in_valid = 1'b1; in_addr = a; in_type = t; in_cacop = c;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  // One request with out_ready high: checks the result one cycle later, then lets it hand off.
  task automatic single(input string name, input logic [31:0] a, input logic [7:0] t,
                        input logic c, input logic [6:0] exp_exc);
    out_ready = 1'b1;
    drive(a, t, c);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_addr !== a || out_exception !== exp_exc || out_cacop !== c) begin
      errors++;
      $display("FAIL %s: valid=%b addr=%h exc=%h cacop=%b, required valid=1 addr=%h exc=%h cacop=%b",
               name, out_valid, out_addr, out_exception, out_cacop, a, exp_exc, c);
    end
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_type = '0; in_cacop = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, out_addr, out_cacop, out_exception, fault_seen, fault_badv, fault_count, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b addr=%h exc=%h seen=%b badv=%h cnt=%0d in_ready=%b, required all 0",
               out_valid, out_addr, out_exception, fault_seen, fault_badv, fault_count, in_ready);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_word_ale();
    single("word_ale", 32'h1002, 8'h0F, 1'b0, `EXP_ALE);
    checks++;
    if (fault_seen !== 1'b1 || fault_badv !== 32'h1002 || fault_count !== 2'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL word_ale_fault: seen=%b badv=%h cnt=%0d valid=%b, required 1 00001002 1 0",
               fault_seen, fault_badv, fault_count, out_valid);
    end
  endtask

  task automatic test_dword_half();
    do_flush();
    checks++;
    if (fault_seen !== 1'b0 || fault_count !== 2'd0) begin
      errors++;
      $display("FAIL flush_clear: seen=%b cnt=%0d, required 0 0", fault_seen, fault_count);
    end
    single("dword_ale", 32'h1004, 8'hFF, 1'b0, `EXP_ALE);
    single("half_ale", 32'h2001, 8'h03, 1'b0, `EXP_ALE);
    single("half_ok", 32'h2002, 8'h03, 1'b0, 7'd0);
    single("dword_ok", 32'h2008, 8'hFF, 1'b0, 7'd0);
    checks++;
    if (fault_count !== 2'd2 || fault_badv !== 32'h1004 || fault_seen !== 1'b1) begin
      errors++;
      $display("FAIL dword_half_fault: cnt=%0d badv=%h seen=%b, required 2 00001004 1",
               fault_count, fault_badv, fault_seen);
    end
  endtask

  task automatic test_cacop_byte();
    single("cacop_word", 32'h1001, 8'h0F, 1'b1, 7'd0);
    single("byte_odd", 32'h0003, 8'h01, 1'b0, 7'd0);
    single("mask_zero", 32'h0007, 8'h00, 1'b0,
`ifdef CACHE_EXP_ILLEGAL_MASK_EN
           `EXP_ALE);
`else
           7'd0);
`endif
    checks++;
`ifdef CACHE_EXP_ILLEGAL_MASK_EN
    if (fault_count !== 2'd3) begin
      errors++;
      $display("FAIL cacop_count: cnt=%0d required 3", fault_count);
    end
`else
    if (fault_count !== 2'd2) begin
      errors++;
      $display("FAIL cacop_count: cnt=%0d required 2", fault_count);
    end
`endif
  endtask

  task automatic test_illegal_mask();
    do_flush();
`ifdef CACHE_EXP_ILLEGAL_MASK_EN
    single("mask5", 32'h0001, 8'h05, 1'b0, `EXP_ALE);
    single("mask5_cacop", 32'h0001, 8'h05, 1'b1, 7'd0);
    checks++;
    if (fault_count !== 2'd1 || fault_badv !== 32'h1) begin
      errors++;
      $display("FAIL mask5_fault: cnt=%0d badv=%h, required 1 00000001", fault_count, fault_badv);
    end
`else
    single("mask5", 32'h0001, 8'h05, 1'b0, 7'd0);
    single("mask5_cacop", 32'h0001, 8'h05, 1'b1, 7'd0);
    checks++;
    if (fault_count !== 2'd0 || fault_seen !== 1'b0) begin
      errors++;
      $display("FAIL mask5_fault: cnt=%0d seen=%b, required 0 0", fault_count, fault_seen);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_flush();
    out_ready = 1'b0;
    drive(32'h100, 8'h0F, 1'b0);
    tick();
    drive(32'h104, 8'h0F, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_addr !== 32'h100) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b valid=%b addr=%h, required 0 1 00000100", in_ready, out_valid, out_addr);
    end
    drive(32'h10A, 8'h0F, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_addr !== 32'h100 || out_exception !== 7'd0) begin
      errors++;
      $display("FAIL bp_hold: in_ready=%b addr=%h exc=%h, required 0 00000100 00", in_ready, out_addr, out_exception);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'h104 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: valid=%b addr=%h in_ready=%b, required 1 00000104 1", out_valid, out_addr, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'h10A || out_exception !== `EXP_ALE) begin
      errors++;
      $display("FAIL bp_third: valid=%b addr=%h exc=%h, required 1 0000010a %h", out_valid, out_addr, out_exception, `EXP_ALE);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || fault_count !== 2'd1 || fault_badv !== 32'h10A) begin
      errors++;
      $display("FAIL bp_drain: valid=%b cnt=%0d badv=%h, required 0 1 0000010a", out_valid, fault_count, fault_badv);
    end
  endtask

  task automatic test_saturation();
    do_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(32'h4001 + 32'(i * 16), 8'h03, 1'b0);
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_addr !== 32'h4001 + 32'(i * 16)) begin
        errors++;
        $display("FAIL sat_stream%0d: in_ready=%b addr=%h, required 1 %h", i, in_ready, out_addr, 32'h4001 + 32'(i * 16));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (fault_count !== 2'd3 || fault_badv !== 32'h4001 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL saturate: cnt=%0d badv=%h valid=%b, required 3 00004001 0", fault_count, fault_badv, out_valid);
    end
  endtask

  task automatic test_flush_mid();
    out_ready = 1'b0;
    drive(32'h5003, 8'h0F, 1'b0);
    tick();
    drive(32'h6003, 8'h0F, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fault_seen !== 1'b0 || fault_badv !== 32'h0 || fault_count !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_mid: valid=%b seen=%b badv=%h cnt=%0d in_ready=%b, required 0 0 0 0 1",
               out_valid, fault_seen, fault_badv, fault_count, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || fault_count !== 2'd0) begin
      errors++;
      $display("FAIL flush_drop: valid=%b cnt=%0d, required 0 0", out_valid, fault_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    single("pre_reset_ale", 32'h7002, 8'h0F, 1'b0, `EXP_ALE);
    out_ready = 1'b0;
    drive(32'h8001, 8'h0F, 1'b1);
    tick();
    drive(32'h8002, 8'h03, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_cacop !== 1'b1) begin
      errors++;
      $display("FAIL stall_before_reset: in_ready=%b cacop=%b, required 0 1", in_ready, out_cacop);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_addr, out_cacop, out_exception, fault_seen, fault_badv, fault_count, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall: valid=%b addr=%h cacop=%b seen=%b badv=%h cnt=%0d in_ready=%b, required all 0",
               out_valid, out_addr, out_cacop, fault_seen, fault_badv, fault_count, in_ready);
    end
    rstn = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_word_ale();
    test_dword_half();
    test_cacop_byte();
    test_illegal_mask();
    test_backpressure();
    test_saturation();
    test_flush_mid();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
